// File: rtl/camera_pkg.sv
// Shared types and constants for the camera pixel reconstructor.
package camera_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS,
    ST_IDLE_LINE,
    ST_BYTE_LO,
    ST_BYTE_HI
  } cam_state_t;

  localparam int H_ACTIVE_DEFAULT = 1280;
  localparam int V_ACTIVE_DEFAULT = 720;
  localparam int RGB565_W         = 16;
  localparam int CAM_BYTE_W       = 8;
  localparam int H_CNT_W          = 11;
  localparam int V_CNT_W          = 10;

endpackage

// File: rtl/cam_input_sync.sv
// Oversampling front end for the raw camera bus. Every raw line goes through
// the same two synchroniser flops so data stays aligned with pclk; a third
// flop on the control lines provides edge detection.
module cam_input_sync
  import camera_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pclk_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [CAM_BYTE_W-1:0] data_in,
  output logic                  pclk_rise,
  output logic                  hs_fall,
  output logic                  vs_rise,
  output logic                  vs_fall,
  output logic                  hsync,
  output logic [CAM_BYTE_W-1:0] data
);

  // bit 0 = s1, bit 1 = s2, bit 2 = s3 (previous s2, for edge detection)
  logic [2:0]            pclk_sr;
  logic [2:0]            hs_sr;
  logic [2:0]            vs_sr;
  logic [CAM_BYTE_W-1:0] data_s1;
  logic [CAM_BYTE_W-1:0] data_s2;

  // Shift all raw camera lines through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_sr <= '0;
      hs_sr   <= '0;
      vs_sr   <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      pclk_sr <= {pclk_sr[1:0], pclk_in};
      hs_sr   <= {hs_sr[1:0], hsync_in};
      vs_sr   <= {vs_sr[1:0], vsync_in};
      data_s1 <= data_in;
      data_s2 <= data_s1;
    end
  end

  assign pclk_rise = pclk_sr[1] & ~pclk_sr[2];
  assign hs_fall   = ~hs_sr[1] & hs_sr[2];
  assign vs_rise   = vs_sr[1] & ~vs_sr[2];
  assign vs_fall   = ~vs_sr[1] & vs_sr[2];
  assign hsync     = hs_sr[1];
  assign data      = data_s2;

endmodule

// File: rtl/camera_pixel_reconstructor.sv
// Rebuilds RGB565 pixels from the 8-bit camera bus, tags them with column and
// row, drops anything outside the active window and flags malformed lines and
// frames without letting them disturb the downstream write stream.
module camera_pixel_reconstructor
  import camera_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic                  clk_camera,
  input  logic                  sys_rst_camera_n,
  input  logic                  cam_pclk,
  input  logic                  cam_hsync,
  input  logic                  cam_vsync,
  input  logic [CAM_BYTE_W-1:0] cam_data,
  input  logic                  err_clr,
  output logic                  pixel_valid,
  output logic [RGB565_W-1:0]   pixel_data,
  output logic [H_CNT_W-1:0]    h_count,
  output logic [V_CNT_W-1:0]    v_count,
  output logic                  frame_done,
  output logic                  line_err,
  output logic                  frame_err
);

  localparam logic [H_CNT_W-1:0] H_LIM  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_ACTIVE - 1);
  localparam logic [V_CNT_W-1:0] V_LIM  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_ACTIVE - 1);

  logic                  pclk_rise;
  logic                  hs_fall;
  logic                  vs_rise;
  logic                  vs_fall;
  logic                  sync_hsync;
  logic [CAM_BYTE_W-1:0] sync_data;

  cam_state_t            state;
  cam_state_t            state_nxt;
  logic [CAM_BYTE_W-1:0] hi_q;
  logic [CAM_BYTE_W-1:0] hi_nxt;
  logic [H_CNT_W-1:0]    h_q;
  logic [H_CNT_W-1:0]    h_nxt;
  logic [V_CNT_W-1:0]    v_q;
  logic [V_CNT_W-1:0]    v_nxt;
  logic                  emit;
  logic                  line_err_evt;
  logic                  frame_err_evt;

  cam_input_sync u_sync (
    .clk       (clk_camera),
    .rst_n     (sys_rst_camera_n),
    .pclk_in   (cam_pclk),
    .hsync_in  (cam_hsync),
    .vsync_in  (cam_vsync),
    .data_in   (cam_data),
    .pclk_rise (pclk_rise),
    .hs_fall   (hs_fall),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .hsync     (sync_hsync),
    .data      (sync_data)
  );

  // Byte-pairing FSM; VSYNC rise outranks line end, which outranks a byte
  always_comb begin
    state_nxt     = state;
    hi_nxt        = hi_q;
    h_nxt         = h_q;
    v_nxt         = v_q;
    emit          = 1'b0;
    line_err_evt  = 1'b0;
    frame_err_evt = 1'b0;
    case (state)
      ST_WAIT_VS: begin
        if (vs_fall) begin
          state_nxt = ST_IDLE_LINE;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      end
      default: begin
        if (vs_rise) begin
          frame_err_evt = (v_q != V_LIM);
          state_nxt     = ST_WAIT_VS;
        end else if (hs_fall && (state != ST_IDLE_LINE)) begin
          line_err_evt = (state == ST_BYTE_LO) || (h_q != H_LIM);
          v_nxt        = (v_q == '1) ? v_q : v_q + V_CNT_W'(1);
          h_nxt        = '0;
          state_nxt    = ST_IDLE_LINE;
        end else if (pclk_rise && sync_hsync) begin
          case (state)
            ST_IDLE_LINE: begin
              hi_nxt    = sync_data;
              h_nxt     = '0;
              state_nxt = ST_BYTE_LO;
            end
            ST_BYTE_LO: begin
              emit      = (h_q < H_LIM) && (v_q < V_LIM);
              h_nxt     = (h_q == '1) ? h_q : h_q + H_CNT_W'(1);
              state_nxt = ST_BYTE_HI;
            end
            ST_BYTE_HI: begin
              hi_nxt    = sync_data;
              state_nxt = ST_BYTE_LO;
            end
            default: state_nxt = ST_WAIT_VS;
          endcase
        end
      end
    endcase
  end

  // State, high-byte latch and line/column counters
  always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
    if (!sys_rst_camera_n) begin
      state <= ST_WAIT_VS;
      hi_q  <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      state <= state_nxt;
      hi_q  <= hi_nxt;
      h_q   <= h_nxt;
      v_q   <= v_nxt;
    end
  end

  // Registered pixel outputs; data and counts hold between pulses
  always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
    if (!sys_rst_camera_n) begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      pixel_data  <= '0;
      h_count     <= '0;
      v_count     <= '0;
    end else begin
      pixel_valid <= emit;
      frame_done  <= emit && (h_q == H_LAST) && (v_q == V_LAST);
      if (emit) begin
        pixel_data <= {hi_q, sync_data};
        h_count    <= h_q;
        v_count    <= v_q;
      end
    end
  end

  // Sticky error flags; a new error in the clear cycle wins
  always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
    if (!sys_rst_camera_n) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      line_err  <= (line_err & ~err_clr) | line_err_evt;
      frame_err <= (frame_err & ~err_clr) | frame_err_evt;
    end
  end

endmodule

// File: tb/tb_camera_pixel_reconstructor.sv
// Self-checking bench for camera_pixel_reconstructor with a 4x4 active window.
// A frame-level model predicts every pixel and the sticky flags from the bytes
// the bench sends; a compare process checks the outputs on every cycle.
module tb_camera_pixel_reconstructor;

  localparam int H = 4;
  localparam int V = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cam_pclk  = 1'b0;
  logic        cam_hsync = 1'b0;
  logic        cam_vsync = 1'b0;
  logic [7:0]  cam_data  = 8'h00;
  logic        err_clr   = 1'b0;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;

  camera_pixel_reconstructor #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_camera       (clk),
    .sys_rst_camera_n (rst_n),
    .cam_pclk         (cam_pclk),
    .cam_hsync        (cam_hsync),
    .cam_vsync        (cam_vsync),
    .cam_data         (cam_data),
    .err_clr          (err_clr),
    .pixel_valid      (pixel_valid),
    .pixel_data       (pixel_data),
    .h_count          (h_count),
    .v_count          (v_count),
    .frame_done       (frame_done),
    .line_err         (line_err),
    .frame_err        (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          h;
    int          v;
    bit          done;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        exp_pix;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          model_v = 0;
  bit          in_frame = 0;
  bit          exp_line_err = 0;
  bit          exp_frame_err = 0;
  int          pv_count = 0;
  int          done_count = 0;
  bit          capture_first = 0;
  logic [15:0] first_data = '0;
  int          first_h = -1;
  int          first_v = -1;
  int          first_pv_cyc = 0;
  int          rise_cyc = 0;
  int          pair_rise_cyc = 0;
  bit          seq_mode = 0;
  logic [7:0]  seq_byte = 8'h12;
  logic [15:0] last_data = '0;
  logic [10:0] last_h = '0;
  logic [9:0]  last_v = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle either a pulse matching the model or held outputs
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = '0;
      last_h    = '0;
      last_v    = '0;
    end else if (pixel_valid) begin
      pv_count++;
      if (frame_done) done_count++;
      if (capture_first) begin
        first_data    = pixel_data;
        first_h       = int'(h_count);
        first_v       = int'(v_count);
        first_pv_cyc  = cyc;
        capture_first = 0;
      end
      if (exp_q.size() == 0) begin
        checkOutput("pixel_valid_unexpected", pixel_valid, 0);
      end else begin
        exp_pix = exp_q.pop_front();
        checkOutput("pixel_data", pixel_data, exp_pix.data);
        checkOutput("h_count", h_count, exp_pix.h);
        checkOutput("v_count", v_count, exp_pix.v);
        checkOutput("frame_done", frame_done, exp_pix.done);
      end
      last_data = pixel_data;
      last_h    = h_count;
      last_v    = v_count;
    end else begin
      checkOutput("idle_hold", {frame_done, pixel_data, h_count, v_count},
                  {1'b0, last_data, last_h, last_v});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One camera byte: data/hsync during pclk low, then a pclk high phase
  task automatic applyStimulus(input logic [7:0] b);
    cam_data  = b;
    cam_hsync = 1'b1;
    cam_pclk  = 1'b0;
    wait_cycles(2);
    cam_pclk  = 1'b1;
    rise_cyc  = cyc;
    wait_cycles(2);
  endtask

  task automatic send_line(input int nbytes, input bit finish);
    logic [7:0] b;
    logic [7:0] hi;
    int         h;
    hi = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (seq_mode) begin
        b        = seq_byte;
        seq_byte = seq_byte + 8'h22;
      end else begin
        b = 8'($urandom);
      end
      if ((i % 2) == 0) begin
        hi = b;
      end else if (in_frame) begin
        h = i / 2;
        if (h < H && model_v < V)
          exp_q.push_back('{data: {hi, b}, h: h, v: model_v,
                            done: ((h == H - 1) && (model_v == V - 1))});
      end
      applyStimulus(b);
      if (i == 1 && model_v == 0) pair_rise_cyc = rise_cyc;
    end
    if (finish) begin
      cam_pclk  = 1'b0;
      wait_cycles(2);
      cam_hsync = 1'b0;
      wait_cycles(4);
      if (in_frame) begin
        if ((nbytes % 2) != 0 || (nbytes / 2) != H) exp_line_err = 1;
        model_v++;
      end
    end
  endtask

  task automatic begin_frame();
    cam_vsync = 1'b1;
    cam_hsync = 1'b0;
    cam_pclk  = 1'b0;
    wait_cycles(3);
    cam_vsync = 1'b0;
    wait_cycles(4);
    in_frame = 1;
    model_v  = 0;
  endtask

  // Frame end; with collide, err_clr lands in the cycle the VSYNC rise is acted on
  task automatic end_frame(input bit collide);
    bit evt;
    cam_vsync = 1'b1;
    cam_hsync = 1'b0;
    cam_pclk  = 1'b0;
    evt       = in_frame && (model_v != V);
    in_frame  = 0;
    if (collide) begin
      wait_cycles(2);
      err_clr = 1'b1;
      wait_cycles(1);
      err_clr = 1'b0;
      exp_line_err  = 0;
      exp_frame_err = evt;
    end else if (evt) begin
      exp_frame_err = 1;
    end
    wait_cycles(6);
    checkOutput("line_err", line_err, exp_line_err);
    checkOutput("frame_err", frame_err, exp_frame_err);
    checkOutput("pixels_outstanding", exp_q.size(), 0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    exp_line_err  = 0;
    exp_frame_err = 0;
    wait_cycles(1);
    checkOutput("line_err_clr", line_err, 0);
    checkOutput("frame_err_clr", frame_err, 0);
  endtask

  int pv0;
  int d0;

  initial begin
    rst_n = 1'b0;
    wait_cycles(3);
    checkOutput("rst_pixel_valid", pixel_valid, 0);
    checkOutput("rst_outputs", {frame_done, pixel_data, h_count, v_count}, 0);
    checkOutput("rst_flags", {line_err, frame_err}, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Nominal 4x4 frame with bytes 0x12, 0x34, ...
    seq_mode      = 1;
    seq_byte      = 8'h12;
    capture_first = 1;
    pv0 = pv_count;
    d0  = done_count;
    begin_frame();
    repeat (4) send_line(8, 1);
    end_frame(0);
    seq_mode = 0;
    checkOutput("nominal_pixel_count", pv_count - pv0, 16);
    checkOutput("nominal_frame_done", done_count - d0, 1);
    checkOutput("first_pixel_data", first_data, 16'h1234);
    checkOutput("first_pixel_h", first_h, 0);
    checkOutput("first_pixel_v", first_v, 0);
    checkOutput("latency", first_pv_cyc - pair_rise_cyc, 3);
    checkOutput("nominal_errs", {line_err, frame_err}, 0);

    // Odd-byte line 1
    clear_errors();
    pv0 = pv_count;
    begin_frame();
    send_line(8, 1);
    send_line(7, 1);
    send_line(8, 1);
    send_line(8, 1);
    end_frame(0);
    checkOutput("odd_line_err", line_err, 1);
    checkOutput("odd_pixel_count", pv_count - pv0, 15);

    // Long lines and an extra line, err_clr colliding with the frame error
    clear_errors();
    pv0 = pv_count;
    d0  = done_count;
    begin_frame();
    repeat (5) send_line(12, 1);
    checkOutput("long_line_err", line_err, 1);
    end_frame(1);
    checkOutput("long_pixel_count", pv_count - pv0, 16);
    checkOutput("long_frame_done", done_count - d0, 1);
    checkOutput("long_frame_err", frame_err, 1);

    // VSYNC rising during line 2
    clear_errors();
    pv0 = pv_count;
    begin_frame();
    send_line(8, 1);
    send_line(8, 1);
    send_line(5, 0);
    end_frame(0);
    checkOutput("midframe_frame_err", frame_err, 1);
    checkOutput("midframe_pixel_count", pv_count - pv0, 10);
    clear_errors();
    begin_frame();
    repeat (4) send_line(8, 1);
    end_frame(0);

    // Reset in the middle of a pixel
    clear_errors();
    begin_frame();
    send_line(7, 1);
    send_line(3, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_outputs", {pixel_valid, frame_done, pixel_data, h_count, v_count}, 0);
    checkOutput("async_rst_flags", {line_err, frame_err}, 0);
    exp_q.delete();
    in_frame      = 0;
    model_v       = 0;
    exp_line_err  = 0;
    exp_frame_err = 0;
    @(negedge clk);
    wait_cycles(2);
    rst_n = 1'b1;
    pv0 = pv_count;
    send_line(5, 1);
    send_line(8, 1);
    end_frame(0);
    checkOutput("post_rst_no_pixels", pv_count - pv0, 0);
    begin_frame();
    repeat (4) send_line(8, 1);
    end_frame(0);

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      int nl;
      int len;
      clear_errors();
      begin_frame();
      nl = $urandom_range(3, 5);
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 12) : 8;
        send_line(len, 1);
      end
      end_frame(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/camera_pixel_reconstructor.md
# camera_pixel_reconstructor

Converts the raw 8-bit parallel camera bus (PCLK, HSYNC, VSYNC, data), oversampled in the camera clock domain, into 16-bit RGB565 pixels tagged with h/v counts. Sits directly upstream of the high-definition frame buffer. It drives the `camera_valid`, `camera_pixel`, `camera_h_count` and `camera_v_count` inputs that feed the stacker and its tlast derivation. Malformed lines and frames are flagged and contained so that a bad frame never desynchronises the DRAM write stream.

## Interface
- `H_ACTIVE`, 1280: active pixels per line; pixels beyond this are dropped.
- `V_ACTIVE`, 720: active lines per frame; lines beyond this are dropped.
- `clk_camera` in 1: sole clock. Must be at least 4x camera PCLK.
- `sys_rst_camera_n` in 1: reset, asynchronous assert, active-low.
- `cam_pclk` in 1: raw camera pixel clock, treated as data and sampled.
- `cam_hsync` in 1: line valid, high during active bytes.
- `cam_vsync` in 1: frame sync, high pulse between frames.
- `cam_data` in 8: byte bus.
- `pixel_valid` out 1: one-cycle pulse per completed in-range pixel.
- `pixel_data` out 16: `{first_byte, second_byte}` RGB565.
- `h_count` out 11: column of the emitted pixel.
- `v_count` out 10: row of the emitted pixel.
- `frame_done` out 1: pulse coincident with the `pixel_valid` of pixel (H_ACTIVE-1, V_ACTIVE-1).
- `line_err` out 1: sticky; a line ended on an odd byte count, or a line's pixel count ≠ H_ACTIVE.
- `frame_err` out 1: sticky; VSYNC arrived mid-frame, or the line count ≠ V_ACTIVE.
- `err_clr` in 1: synchronous clear of both sticky flags.

## Operation
- **Input capture:**
  - `cam_pclk`, `cam_hsync`, `cam_vsync` and `cam_data` pass through an identical 2-flop synchroniser (s1, s2).
  - A third flop (s3) on pclk provides edge detection: `pclk_rise = s2 & ~s3`.
  - Data is used only at the s2 stage, so it is aligned with pclk.
- **FSM states:**
  - WAIT_VS (reset state): ignore all bytes. On VSYNC falling edge → IDLE_LINE, v=0.
  - IDLE_LINE: on `pclk_rise` with hsync=1 → latch byte into `hi`, go to BYTE_LO, h=0 for the first pixel.
  - BYTE_LO: on `pclk_rise` with hsync=1 → form pixel `{hi, byte}`, emit if h<H_ACTIVE and v<V_ACTIVE, h++ (saturating at 2047), go to BYTE_HI.
  - BYTE_HI: on `pclk_rise` with hsync=1 → latch `hi`, go to BYTE_LO.
  - Line end (hsync falling edge, from BYTE_HI or BYTE_LO):
    - If in BYTE_LO (odd byte count), discard the partial byte and set `line_err`.
    - If pixel count ≠ H_ACTIVE, set `line_err`.
    - v++ (saturating at 1023), h=0, go to IDLE_LINE.
  - VSYNC rising edge in any state except WAIT_VS:
    - If v ≠ V_ACTIVE, set `frame_err`.
    - Discard any partial pixel and go to WAIT_VS.
- **Dropped pixels and lines:** out-of-range pixels and lines do not pulse `pixel_valid`. Counts still advance, saturating.
- **Simultaneous events:**
  - VSYNC rise outranks hsync fall, which outranks `pclk_rise`.
  - `err_clr` in the same cycle as a new error event: the flag stays set.

## Timing
- **Latency:** from a raw `cam_pclk` rising edge to the `pixel_valid` pulse is 3 `clk_camera` cycles (2 synchroniser stages, then the registered output).
- **Output registers:** `pixel_data`, `h_count` and `v_count` are registered together. They update only with `pixel_valid` and hold their values otherwise.
- **No backpressure:** downstream must accept every pulse.
- **Reset:** all outputs are 0, all flags are 0, and the FSM is in WAIT_VS. Reset mid-line drops the partial line; the next VSYNC falling edge starts a clean frame.

## Structure
- Package `camera_pkg`:
  - state typedef `cam_state_t`
  - `H_ACTIVE_DEFAULT` and `V_ACTIVE_DEFAULT`
  - `RGB565_W` = 16
- Sub-module `cam_input_sync`: 3-flop sampler for pclk/hsync/vsync/data. Outputs `pclk_rise`, `hs_fall`, `vs_rise`, `vs_fall` and aligned data.

## Test plan
- **Nominal 4x4 frame** (H_ACTIVE=4, V_ACTIVE=4; bytes 0x12,0x34,… with pclk = clk/4): expect 16 `pixel_valid` pulses, first `pixel_data`=0x1234 at h=0,v=0, `frame_done` with h=3,v=3, no errors.
- **Odd-byte line** (line 1 carries 7 bytes): expect 3 pixels on line 1, `line_err`=1, line 2 pixel 0 correct at h=0,v=2.
- **Long line and extra lines** (6 pixels per line, 5 lines): expect only h≤3, v≤3 emitted, `line_err`=1, `frame_err`=1, `frame_done` exactly once.
- **Mid-frame VSYNC** (VSYNC rises during line 2): expect an immediate stop, `frame_err`=1; the next frame restarts at h=0,v=0.
- **Reset and clear:**
  - Assert `sys_rst_camera_n`=0 mid-pixel: expect outputs 0 asynchronously, no `pixel_valid` until after the next VSYNC falling edge.
  - `err_clr` pulse clears both flags.
- **Latency:** check `pixel_valid` arrives 3 cycles after the raw pclk edge of the second byte.
